// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder family.
//   state_t      : FSM encoding used by decoder_scan (IDLE, DIRECT, SCAN)
//   MODE_DIRECT  : mode input value that decodes sel every cycle
//   MODE_SCAN    : mode input value that auto-sweeps across all lines
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder with enable.
// Ports:
//   en   in  1               0 forces the output to all-zero
//   sel  in  SEL_W           line index
//   line out 2**SEL_W        one-hot of sel when en=1, else zero
module onehot_dec #(
    parameter int SEL_W = 2
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   line
);

    always_comb begin
        line = '0;
        if (en) begin
            line[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with DIRECT and SCAN modes.
// DIRECT decodes sel every cycle; SCAN sweeps the active line from 0 to
// N_OUT-1 and back, holding each line for dwell+1 cycles.
// Ports:
//   clk    in  1        rising-edge clock
//   rst_n  in  1        synchronous active-low reset
//   en     in  1        enable; 0 blanks all outputs
//   mode   in  1        MODE_DIRECT / MODE_SCAN
//   sel    in  SEL_W    line index for DIRECT
//   dwell  in  DWELL_W  SCAN hold length minus one
//   d_out  out N_OUT    registered one-hot (zero when blanked)
//   idx    out SEL_W    registered index of the active line
//   active out 1        registered, 1 when d_out is non-zero
//   wrap   out 1        one-cycle pulse when SCAN returns from N_OUT-1 to 0
// The current FSM state is visible on the internal signal state_q.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [2**SEL_W-1:0]   d_out,
    output logic [SEL_W-1:0]      idx,
    output logic                  active,
    output logic                  wrap
);

    state_t               state_q, state_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]     idx_d;
    logic                 line_en;
    logic                 wrap_d;
    logic [2**SEL_W-1:0]  line_d;

    // Next state is a pure function of en/mode; the previous state only
    // matters to tell SCAN entry apart from SCAN steady state.
    always_comb begin
        state_d = ST_IDLE;
        if (en) begin
            state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
        end
    end

    always_comb begin
        idx_d   = idx;
        cnt_d   = cnt_q;
        line_en = 1'b0;
        wrap_d  = 1'b0;
        case (state_d)
            ST_DIRECT: begin
                idx_d   = sel;
                cnt_d   = '0;
                line_en = 1'b1;
            end
            ST_SCAN: begin
                line_en = 1'b1;
                if (state_q != ST_SCAN) begin
                    // Sweep always restarts at line 0 on entry.
                    idx_d = '0;
                    cnt_d = '0;
                end else if (cnt_q >= dwell) begin
                    // >= rather than == so a dwell lowered below cnt
                    // advances immediately instead of wrapping cnt.
                    cnt_d  = '0;
                    idx_d  = idx + SEL_W'(1);
                    wrap_d = &idx;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: begin
                // IDLE: idx and cnt hold, output blanked.
            end
        endcase
    end

    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .en   (line_en),
        .sel  (idx_d),
        .line (line_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx     <= '0;
            d_out   <= '0;
            active  <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx     <= idx_d;
            d_out   <= line_d;
            active  <= line_en;
            wrap    <= wrap_d;
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// Table-driven bench for decoder_scan (SEL_W=2, DWELL_W=4).
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] sel = '0;
    logic [3:0] dwell = '0;
    logic [3:0] d_out;
    logic [1:0] idx;
    logic       active;
    logic       wrap;

    int n_cmp = 0;
    int n_bad = 0;
    logic inv_on = 1'b0;

    decoder_scan #(.SEL_W(2), .DWELL_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .sel    (sel),
        .dwell  (dwell),
        .d_out  (d_out),
        .idx    (idx),
        .active (active),
        .wrap   (wrap)
    );

    // clock
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] dwell;
        logic [3:0] exp_d;
        logic [1:0] exp_idx;
        logic       exp_act;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic e, input logic m,
                                input logic [1:0] s, input logic [3:0] dw,
                                input logic [3:0] d, input logic [1:0] ix,
                                input logic a, input logic w);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.sel = s; v.dwell = dw;
        v.exp_d = d; v.exp_idx = ix; v.exp_act = a; v.exp_wrap = w;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one vector, let one edge pass, compare outputs 1 time unit later.
    task automatic apply(input string tag, input vec_t v);
        rst_n = v.rst_n; en = v.en; mode = v.mode; sel = v.sel; dwell = v.dwell;
        @(posedge clk);
        #1;
        chk({tag, ".d_out"},  int'(d_out),  int'(v.exp_d));
        chk({tag, ".idx"},    int'(idx),    int'(v.exp_idx));
        chk({tag, ".active"}, int'(active), int'(v.exp_act));
        chk({tag, ".wrap"},   int'(wrap),   int'(v.exp_wrap));
    endtask

    // One-hot / idx invariant, sampled on every falling edge.
    always @(negedge clk) begin
        if (inv_on) begin
            n_cmp++;
            if (!$onehot0(d_out) || (active != (d_out != 4'b0000)) ||
                (active && d_out != (4'b0001 << idx))) begin
                n_bad++;
                $display("FAIL invariant: d_out=%b idx=%0d active=%0d", d_out, idx, active);
            end
        end
    end

    initial begin
        vec_t v;
        logic [3:0] oh;

        // Reset held with en=1, mode=SCAN
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 2, 4'b0000, 0, 0, 0);
        // Release: SCAN entry, dwell=2 -> each line held 3 cycles
        for (int k = 0; k < 3; k++) add(1, 1, 1, 0, 2, 4'b0001, 0, 1, 0);
        for (int ln = 1; ln < 4; ln++) begin
            oh = 4'b0001 << ln;
            for (int k = 0; k < 3; k++) add(1, 1, 1, 0, 2, oh, 2'(ln), 1, 0);
        end
        add(1, 1, 1, 0, 2, 4'b0001, 0, 1, 1);
        add(1, 1, 1, 0, 2, 4'b0001, 0, 1, 0);
        add(1, 1, 1, 0, 2, 4'b0001, 0, 1, 0);
        add(1, 1, 1, 0, 2, 4'b0010, 1, 1, 0);
        // DIRECT sweep
        add(1, 1, 0, 0, 2, 4'b0001, 0, 1, 0);
        add(1, 1, 0, 1, 2, 4'b0010, 1, 1, 0);
        add(1, 1, 0, 2, 2, 4'b0100, 2, 1, 0);
        add(1, 1, 0, 3, 2, 4'b1000, 3, 1, 0);
        // Blank: idx holds its last value
        add(1, 0, 0, 1, 2, 4'b0000, 3, 0, 0);
        add(1, 0, 1, 1, 2, 4'b0000, 3, 0, 0);
        // SCAN with dwell=0: advance every cycle, wrap every 4th
        add(1, 1, 1, 0, 0, 4'b0001, 0, 1, 0);
        add(1, 1, 1, 0, 0, 4'b0010, 1, 1, 0);
        add(1, 1, 1, 0, 0, 4'b0100, 2, 1, 0);
        add(1, 1, 1, 0, 0, 4'b1000, 3, 1, 0);
        add(1, 1, 1, 0, 0, 4'b0001, 0, 1, 1);
        add(1, 1, 1, 0, 0, 4'b0010, 1, 1, 0);
        add(1, 1, 1, 0, 0, 4'b0100, 2, 1, 0);
        add(1, 1, 1, 0, 0, 4'b1000, 3, 1, 0);
        add(1, 1, 1, 0, 0, 4'b0001, 0, 1, 1);

        inv_on = 1'b1;
        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

        // Dwell lowered mid-line
        vecs.delete();
        add(0, 1, 1, 0, 9, 4'b0000, 0, 0, 0);
        add(1, 1, 1, 0, 9, 4'b0001, 0, 1, 0);
        for (int k = 0; k < 6; k++) add(1, 1, 1, 0, 9, 4'b0001, 0, 1, 0);
        foreach (vecs[i]) apply($sformatf("dwl%0d", i), vecs[i]);
        chk("dwl.cnt_before", int'(dut.cnt_q), 6);
        vecs.delete();
        add(1, 1, 1, 0, 3, 4'b0010, 1, 1, 0);
        for (int k = 0; k < 3; k++) add(1, 1, 1, 0, 3, 4'b0010, 1, 1, 0);
        add(1, 1, 1, 0, 3, 4'b0100, 2, 1, 0);
        // Mode interruption at idx=2
        add(1, 1, 0, 3, 3, 4'b1000, 3, 1, 0);
        add(1, 1, 1, 3, 3, 4'b0001, 0, 1, 0);
        // Enable pulsed low at idx=2
        add(1, 1, 1, 0, 0, 4'b0010, 1, 1, 0);
        add(1, 1, 1, 0, 0, 4'b0100, 2, 1, 0);
        add(1, 0, 1, 0, 0, 4'b0000, 2, 0, 0);
        add(1, 1, 1, 0, 0, 4'b0001, 0, 1, 0);
        // Reset mid-scan at idx=3, cnt=1
        add(1, 1, 1, 0, 0, 4'b0010, 1, 1, 0);
        add(1, 1, 1, 0, 0, 4'b0100, 2, 1, 0);
        add(1, 1, 1, 0, 0, 4'b1000, 3, 1, 0);
        add(1, 1, 1, 0, 2, 4'b1000, 3, 1, 0);
        foreach (vecs[i]) apply($sformatf("seq%0d", i), vecs[i]);
        chk("rst.cnt_before", int'(dut.cnt_q), 1);

        v.rst_n = 0; v.en = 1; v.mode = 1; v.sel = 0; v.dwell = 2;
        v.exp_d = 4'b0000; v.exp_idx = 0; v.exp_act = 0; v.exp_wrap = 0;
        apply("rst_mid", v);
        chk("rst_mid.cnt", int'(dut.cnt_q), 0);
        v.rst_n = 1; v.exp_d = 4'b0001; v.exp_act = 1;
        apply("rst_rel", v);
        chk("rst_rel.cnt", int'(dut.cnt_q), 0);

        inv_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
